// File: rtl/bcd_xs3_seq.sv
// bcd_xs3_seq
// -----------
// Multi-digit BCD to Excess-3 conversion sequencer. A packed DIGITS-digit BCD
// word is accepted over a valid/ready handshake and copied into a shadow
// register. One shared 4-bit converter (digit + 3) then processes one digit
// per clock, least-significant digit first. The packed Excess-3 word is
// returned over a second valid/ready handshake, together with a flag that is
// set when any input digit of that word was greater than 9.
//
// Ports:
//   clk        system clock, rising-edge active
//   rst        asynchronous, active-high reset
//   in_valid   source presents bcd_in
//   in_ready   block can accept a word (IDLE only)
//   bcd_in     packed BCD, digit i at bits [4i+3:4i]
//   out_valid  xs3_out and err are valid (DONE only)
//   out_ready  sink accepts the result
//   xs3_out    packed Excess-3 result, same layout as bcd_in
//   err        at least one digit of the word was greater than 9
//   busy       high while converting or holding a result
module bcd_xs3_seq #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] xs3_out,
  output logic                err,
  output logic                busy
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Returns {digit_error, excess3_digit}. Non-BCD digits map to 4'b0000 and
  // raise the error bit.
  function automatic logic [4:0] xs3_conv(input logic [3:0] d);
    logic [4:0] r;
    if (d <= 4'd9) begin
      r = {1'b0, d + 4'd3};
    end else begin
      r = {1'b1, 4'b0000};
    end
    return r;
  endfunction

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [W-1:0]     shadow_q;
  logic [W-1:0]     result_q;
  logic             err_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [3:0]       digit_d;
  logic [3:0]       xs3_digit_d;
  logic             dig_err_d;

  // Shared digit converter: selects shadow digit idx and converts it.
  always_comb begin
    digit_d     = 4'b0000;
    xs3_digit_d = 4'b0000;
    dig_err_d   = 1'b0;
    digit_d     = shadow_q[{idx_q, 2'b00} +: 4];
    {dig_err_d, xs3_digit_d} = xs3_conv(digit_d);
  end

  // Sequencer FSM with registered handshake and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= IDX_ZERO;
      shadow_q    <= {W{1'b0}};
      result_q    <= {W{1'b0}};
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            shadow_q   <= bcd_in;
            result_q   <= {W{1'b0}};
            err_q      <= 1'b0;
            idx_q      <= IDX_ZERO;
            state_q    <= ST_CONV;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end else begin
            state_q    <= ST_IDLE;
          end
        end
        ST_CONV: begin
          result_q[{idx_q, 2'b00} +: 4] <= xs3_digit_d;
          err_q <= err_q | dig_err_d;
          if (idx_q == IDX_LAST) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
          end else begin
            idx_q <= idx_q + IDX_ONE;
          end
        end
        ST_DONE: begin
          // Result and err are held until the sink takes them; the result
          // register keeps its value after the handshake.
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            state_q     <= ST_DONE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          idx_q       <= IDX_ZERO;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign xs3_out   = result_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcd_xs3_seq.sv
module tb_bcd_xs3_seq;

  logic        clk = 1'b0;
  logic        rst;

  // DIGITS = 4 instance
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_err, a_busy;
  logic [15:0] a_bcd, a_xs3;

  // DIGITS = 1 instance
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_err, b_busy;
  logic [3:0]  b_bcd, b_xs3;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bcd_xs3_seq #(.DIGITS(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .bcd_in(a_bcd),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .xs3_out(a_xs3),
    .err(a_err), .busy(a_busy)
  );

  bcd_xs3_seq #(.DIGITS(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .bcd_in(b_bcd),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .xs3_out(b_xs3),
    .err(b_err), .busy(b_busy)
  );

  // Reference: each digit d becomes d+3 when d<=9, otherwise 0 with the
  // word error flag set. Returns {err, xs3}.
  function automatic logic [32:0] ref_xs3(input logic [31:0] bcd, input int nd);
    logic [31:0] x = 32'd0;
    logic        e = 1'b0;
    for (int i = 0; i < nd; i++) begin
      int d = int'((bcd >> (4 * i)) & 32'hF);
      if (d > 9) e = 1'b1;
      else       x = x + (32'(d + 3) << (4 * i));
    end
    return {e, x};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full word through the 4-digit instance; stall = cycles out_ready is
  // held low in DONE. Noise on the inputs during conversion must be ignored.
  task automatic xfer4(input logic [15:0] bcd, input int stall);
    logic [32:0] r;
    r = ref_xs3({16'd0, bcd}, 4);
    chk("a_in_ready_idle", {31'd0, a_in_ready}, 32'd1);
    a_bcd = bcd; a_in_valid = 1'b1; a_out_ready = 1'b0;
    tick();
    for (int c = 1; c < 4; c++) begin
      a_in_valid  = 1'($urandom_range(0, 1));
      a_bcd       = 16'($urandom);
      a_out_ready = 1'($urandom_range(0, 1));
      tick();
      chk("a_conv_out_valid", {31'd0, a_out_valid}, 32'd0);
      chk("a_conv_in_ready",  {31'd0, a_in_ready},  32'd0);
      chk("a_conv_busy",      {31'd0, a_busy},      32'd1);
    end
    a_in_valid = 1'b0; a_out_ready = 1'b0;
    tick();
    chk("a_done_valid", {31'd0, a_out_valid}, 32'd1);
    chk("a_done_xs3",   {16'd0, a_xs3},       r[31:0]);
    chk("a_done_err",   {31'd0, a_err},       {31'd0, r[32]});
    for (int s = 0; s < stall; s++) begin
      tick();
      chk("a_hold_valid",    {31'd0, a_out_valid}, 32'd1);
      chk("a_hold_xs3",      {16'd0, a_xs3},       r[31:0]);
      chk("a_hold_err",      {31'd0, a_err},       {31'd0, r[32]});
      chk("a_hold_in_ready", {31'd0, a_in_ready},  32'd0);
    end
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    chk("a_post_valid",    {31'd0, a_out_valid}, 32'd0);
    chk("a_post_in_ready", {31'd0, a_in_ready},  32'd1);
    chk("a_post_busy",     {31'd0, a_busy},      32'd0);
    chk("a_post_xs3_kept", {16'd0, a_xs3},       r[31:0]);
  endtask

  task automatic xfer1(input logic [3:0] bcd);
    logic [32:0] r;
    r = ref_xs3({28'd0, bcd}, 1);
    b_bcd = bcd; b_in_valid = 1'b1; b_out_ready = 1'b0;
    tick();
    b_in_valid = 1'b0;
    chk("b_conv_valid", {31'd0, b_out_valid}, 32'd0);
    tick();
    chk("b_done_valid", {31'd0, b_out_valid}, 32'd1);
    chk("b_done_xs3",   {28'd0, b_xs3},       r[31:0]);
    chk("b_done_err",   {31'd0, b_err},       {31'd0, r[32]});
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    chk("b_post_in_ready", {31'd0, b_in_ready}, 32'd1);
  endtask

  initial begin
    logic [32:0] r;
    logic [15:0] w;
    rst = 1'b1;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_bcd = 16'd0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_bcd = 4'd0;
    tick();
    chk("rst_in_ready",  {31'd0, a_in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("rst_busy",      {31'd0, a_busy},      32'd0);
    chk("rst_xs3",       {16'd0, a_xs3},       32'd0);
    chk("rst_err",       {31'd0, a_err},       32'd0);
    chk("rst_b_in_ready",{31'd0, b_in_ready},  32'd1);
    rst = 1'b0;
    tick();

    // Basic word, then invalid digit, then err cleared on the next word.
    xfer4(16'h1234, 0);
    xfer4(16'h12A4, 0);
    xfer4(16'h0001, 0);
    // Long stall in DONE.
    xfer4(16'h1234, 10);

    // Back to back with in_valid held high and out_ready = 1.
    a_bcd = 16'h9999; a_in_valid = 1'b1; a_out_ready = 1'b1;
    tick();
    a_bcd = 16'h0000;
    for (int c = 0; c < 3; c++) tick();
    chk("b2b_first_valid", {31'd0, a_out_valid}, 32'd0);
    tick();
    chk("b2b_first_valid", {31'd0, a_out_valid}, 32'd1);
    chk("b2b_first_xs3",   {16'd0, a_xs3},       32'h0000CCCC);
    chk("b2b_first_err",   {31'd0, a_err},       32'd0);
    tick();
    chk("b2b_idle_in_ready", {31'd0, a_in_ready}, 32'd1);
    tick();
    chk("b2b_second_capture", {31'd0, a_busy}, 32'd1);
    a_in_valid = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    chk("b2b_second_valid", {31'd0, a_out_valid}, 32'd1);
    chk("b2b_second_xs3",   {16'd0, a_xs3},       32'h00003333);
    chk("b2b_second_err",   {31'd0, a_err},       32'd0);
    tick();
    a_out_ready = 1'b0;
    chk("b2b_end_in_ready", {31'd0, a_in_ready}, 32'd1);

    // Asynchronous reset in the middle of a conversion (idx = 2).
    a_bcd = 16'h9876; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_in_ready",  {31'd0, a_in_ready},  32'd1);
    chk("arst_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("arst_busy",      {31'd0, a_busy},      32'd0);
    chk("arst_xs3",       {16'd0, a_xs3},       32'd0);
    chk("arst_err",       {31'd0, a_err},       32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("arst_no_valid", {31'd0, a_out_valid}, 32'd0);
    xfer4(16'h0505, 0);

    // Randomized words with random stalls.
    for (int n = 0; n < 24; n++) begin
      w = 16'd0;
      for (int i = 0; i < 4; i++)
        w[4*i +: 4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15))
                                                  : 4'($urandom_range(0, 9));
      xfer4(w, int'($urandom_range(0, 3)));
    end

    // Single-digit instance.
    xfer1(4'hF);
    xfer1(4'h9);
    for (int n = 0; n < 8; n++) xfer1(4'($urandom_range(0, 15)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
